// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one imem read per instruction and latches the word into IR.
// Handles redirect flushes and response timeouts, with at most one request outstanding.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_o,
    output logic [31:0] ir_pc_o,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        pc_adv,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic [CW-1:0] cnt;
    logic          aligned;

    assign aligned   = (pc_i[1:0] == 2'b00);
    assign imem_req  = (state == S_ISSUE) && aligned;
    assign imem_addr = (state == S_ISSUE) ? pc_i : addr_q;
    assign pc_adv    = ir_valid & ir_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= 32'h0;
            ir_o      <= 32'h0;
            ir_pc_o   <= RESET_PC;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ir_valid <= 1'b0;
                    state    <= flush ? S_IDLE : S_ISSUE;
                end
                S_ISSUE: begin
                    addr_q <= pc_i;
                    cnt    <= '0;
                    // A request already on the bus must be drained even when flushed
                    if (!aligned) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_ERR;
                            fetch_err <= 1'b1;
                        end
                    end else begin
                        state <= flush ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= imem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (imem_rvalid) begin
                        ir_o     <= imem_rdata;
                        ir_pc_o  <= addr_q;
                        ir_valid <= 1'b1;
                        state    <= S_HOLD;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= S_ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (flush || ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // The owed response retires the drain even if another flush arrives with it
                    if (imem_rvalid) begin
                        state <= S_IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= S_ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    ir_valid  <= 1'b0;
                    fetch_err <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit: normal fetch, decode stall, flushes, timeout and misalignment.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir_o;
    logic [31:0] ir_pc_o;
    logic        ir_valid;
    logic        ir_ready;
    logic        pc_adv;
    logic        fetch_err;

    int passed = 0;
    int total  = 0;
    logic seen_dead = 1'b0;

    ifetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_o(ir_o), .ir_pc_o(ir_pc_o), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .pc_adv(pc_adv), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Flags any cycle where the flushed word is presented to decode
    always @(negedge clk) begin
        if (ir_valid === 1'b1 && ir_o === 32'hDEADBEEF) seen_dead <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_i = 32'h3000; flush = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0;
        tick();
        total++;
        if ({imem_req, ir_valid, fetch_err, pc_adv} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {imem_req, ir_valid, fetch_err, pc_adv});
        else passed++;
        total++;
        if (imem_addr !== 32'h0 || ir_o !== 32'h0)
            $display("[TB] FAIL reset_data: got addr=%h ir=%h expected 0/0", imem_addr, ir_o);
        else passed++;
        total++;
        if (ir_pc_o !== 32'h3000)
            $display("[TB] FAIL reset_ir_pc: got %h expected 00003000", ir_pc_o);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic_fetch();
        ir_ready = 1'b1;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
            $display("[TB] FAIL basic_req: got req=%b addr=%h expected 1/00003000", imem_req, imem_addr);
        else passed++;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h8C010004;
        total++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0)
            $display("[TB] FAIL basic_wait: got req=%b valid=%b expected 0/0", imem_req, ir_valid);
        else passed++;
        tick();
        imem_rvalid = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir_o !== 32'h8C010004 || ir_pc_o !== 32'h3000)
            $display("[TB] FAIL basic_ir: got v=%b ir=%h pc=%h expected 1/8c010004/00003000", ir_valid, ir_o, ir_pc_o);
        else passed++;
        total++;
        if (pc_adv !== 1'b1)
            $display("[TB] FAIL basic_pc_adv: got %b expected 1", pc_adv);
        else passed++;
        tick();
        pc_i = 32'h3004;
        total++;
        if (pc_adv !== 1'b0 || ir_valid !== 1'b0)
            $display("[TB] FAIL basic_adv_once: got adv=%b valid=%b expected 0/0", pc_adv, ir_valid);
        else passed++;
        ir_ready = 1'b0;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3004)
            $display("[TB] FAIL basic_next_addr: got req=%b addr=%h expected 1/00003004", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_hold_stall();
        int bad;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h20420001;
        tick();
        imem_rvalid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ir_valid !== 1'b1 || ir_o !== 32'h20420001 || pc_adv !== 1'b0 || imem_req !== 1'b0) bad++;
            tick();
        end
        total++;
        if (bad != 0)
            $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0", bad);
        else passed++;
        ir_ready = 1'b1;
        #1;
        total++;
        if (pc_adv !== 1'b1 || ir_pc_o !== 32'h3004)
            $display("[TB] FAIL hold_release: got adv=%b pc=%h expected 1/00003004", pc_adv, ir_pc_o);
        else passed++;
        tick();
        pc_i = 32'h3008;
        ir_ready = 1'b0;
    endtask

    task automatic test_flush_wait();
        tick();
        tick();
        flush = 1'b1;
        pc_i  = 32'h3100;
        #1;
        total++;
        if (pc_adv !== 1'b0)
            $display("[TB] FAIL flush_wait_adv: got %b expected 0", pc_adv);
        else passed++;
        tick();
        flush = 1'b0;
        tick();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        total++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b0)
            $display("[TB] FAIL flush_drain_done: got v=%b req=%b expected 0/0", ir_valid, imem_req);
        else passed++;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3100)
            $display("[TB] FAIL flush_redirect: got req=%b addr=%h expected 1/00003100", imem_req, imem_addr);
        else passed++;
        total++;
        if (seen_dead !== 1'b0 || ir_o === 32'hDEADBEEF)
            $display("[TB] FAIL flush_dropped: got seen=%b ir=%h expected 0/not deadbeef", seen_dead, ir_o);
        else passed++;
    endtask

    task automatic test_flush_rvalid_same();
        tick();
        flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
        tick();
        flush = 1'b0; imem_rvalid = 1'b0;
        total++;
        if (ir_valid !== 1'b0)
            $display("[TB] FAIL same_valid: got %b expected 0", ir_valid);
        else passed++;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3100)
            $display("[TB] FAIL same_no_drain: got req=%b addr=%h expected 1/00003100", imem_req, imem_addr);
        else passed++;
        total++;
        if (ir_o !== 32'h20420001)
            $display("[TB] FAIL same_ir_kept: got %h expected 20420001", ir_o);
        else passed++;
    endtask

    task automatic test_timeout();
        int bad;
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (fetch_err !== 1'b0)
            $display("[TB] FAIL timeout_early: got %b expected 0", fetch_err);
        else passed++;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (fetch_err !== 1'b1)
            $display("[TB] FAIL timeout_err: got %b expected 1", fetch_err);
        else passed++;
        bad = 0;
        imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) imem_rvalid = 1'b0;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0) bad++;
            tick();
        end
        total++;
        if (bad != 0)
            $display("[TB] FAIL timeout_sticky: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_misaligned();
        rst = 1'b1; pc_i = 32'h3002;
        tick();
        rst = 1'b0;
        total++;
        if (fetch_err !== 1'b0)
            $display("[TB] FAIL misalign_reset: got %b expected 0", fetch_err);
        else passed++;
        tick();
        total++;
        if (imem_req !== 1'b0)
            $display("[TB] FAIL misalign_no_req: got %b expected 0", imem_req);
        else passed++;
        tick();
        total++;
        if (fetch_err !== 1'b1)
            $display("[TB] FAIL misalign_err: got %b expected 1", fetch_err);
        else passed++;
        rst = 1'b1; pc_i = 32'h3000;
        tick();
        rst = 1'b0;
        total++;
        if (fetch_err !== 1'b0)
            $display("[TB] FAIL misalign_clear: got %b expected 0", fetch_err);
        else passed++;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
            $display("[TB] FAIL misalign_refetch: got req=%b addr=%h expected 1/00003000", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_flush_hold();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA5555;
        tick();
        imem_rvalid = 1'b0;
        ir_ready = 1'b1; flush = 1'b1;
        #1;
        total++;
        if (ir_valid !== 1'b1 || pc_adv !== 1'b0)
            $display("[TB] FAIL hold_flush_adv: got v=%b adv=%b expected 1/0", ir_valid, pc_adv);
        else passed++;
        tick();
        flush = 1'b0; ir_ready = 1'b0;
        total++;
        if (ir_valid !== 1'b0 || ir_o !== 32'hAAAA5555)
            $display("[TB] FAIL hold_flush_idle: got v=%b ir=%h expected 0/aaaa5555", ir_valid, ir_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_flush_wait();
        test_flush_rvalid_same();
        test_timeout();
        test_misaligned();
        test_flush_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
